// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, queue FSM state encoding and baud-select codes
// used by uart_tx_queue and uart_byte_tx.
package uart_pkg;

  localparam int unsigned UART_BYTE_W = 8;

  typedef logic [1:0] txq_state_t;

  localparam txq_state_t StIdle = 2'd0;
  localparam txq_state_t StSend = 2'd1;
  localparam txq_state_t StWait = 2'd2;
  localparam txq_state_t StGap  = 2'd3;

  typedef logic [2:0] baud_sel_t;

  localparam baud_sel_t Baud9600   = 3'd0;
  localparam baud_sel_t Baud19200  = 3'd1;
  localparam baud_sel_t Baud38400  = 3'd2;
  localparam baud_sel_t Baud57600  = 3'd3;
  localparam baud_sel_t Baud115200 = 3'd4;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered level and full flag; head is the entry at the read
// pointer, so a freshly written byte is only visible after the write edge.
module uart_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             full,
  output logic [AW:0]      level,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      level_q, level_d;
  logic             full_q;
  logic             wr_ok, rd_ok;

  // Full is the registered flag, so a write is refused even if a pop frees a slot this cycle.
  assign wr_ok = wr_en & ~full_q;
  assign rd_ok = rd_en & (level_q != '0);

  always_comb begin
    level_d = level_q;
    unique case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + AW'(1);
      if (rd_ok) rptr_q <= rptr_q + AW'(1);
      level_q <= level_d;
      full_q  <= (level_d == (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr_q] <= wr_data;
  end

  assign full  = full_q;
  assign level = level_q;
  assign head  = mem_q[rptr_q];

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue and send scheduler in front of uart_byte_tx. Define UART_TXQ_OVF_CNT_EN to
// count dropped writes on o_Ovf_Cnt; otherwise that output is tied to zero.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned GAP_CYC = 0,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_WR_En,
  input  logic [UART_BYTE_W-1:0] i_WR_Din,
  output logic                   o_WR_Full,
  output logic [AW:0]            o_Level,
  input  logic                   i_TXD_Done,
  output logic [UART_BYTE_W-1:0] o_TXD_Din,
  output logic                   o_TXD_En,
  output logic                   o_Busy,
  output logic [15:0]            o_Ovf_Cnt
);

  localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  txq_state_t             state_q, state_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [UART_BYTE_W-1:0] din_q;
  logic [UART_BYTE_W-1:0] head;
  logic                   pop, load;

  uart_sync_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(UART_BYTE_W)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (i_WR_En),
    .wr_data(i_WR_Din),
    .rd_en  (pop),
    .full   (o_WR_Full),
    .level  (o_Level),
    .head   (head)
  );

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (o_Level != '0) begin
          state_d = StSend;
          load    = 1'b1;
        end
      end
      StSend: begin
        pop     = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        if (i_TXD_Done) begin
          if (GAP_CYC > 0) begin
            state_d = StGap;
            gap_d   = GW'(GAP_CYC - 1);
          end else begin
            state_d = StIdle;
          end
        end
      end
      StGap: begin
        if (gap_q == '0) state_d = StIdle;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      gap_q   <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      if (load) din_q <= head;
    end
  end

  assign o_TXD_Din = din_q;
  assign o_TXD_En  = (state_q == StSend);
  assign o_Busy    = (state_q != StIdle) || (o_Level != '0);

`ifdef UART_TXQ_OVF_CNT_EN
  logic [15:0] ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= '0;
    end else if (i_WR_En && o_WR_Full && (ovf_q != 16'hFFFF)) begin
      ovf_q <= ovf_q + 16'd1;
    end
  end

  assign o_Ovf_Cnt = ovf_q;
`else
  assign o_Ovf_Cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench: two queues (GAP_CYC 0 and 5) share the write stream and are compared
// every cycle against a queue-and-timestamp reference model.
module tb_uart_tx_queue;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int          GAP1  = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [7:0]  wr_din;
  logic        done    [2];
  logic        full    [2];
  logic [AW:0] level   [2];
  logic [7:0]  txd_din [2];
  logic        txd_en  [2];
  logic        busy    [2];
  logic [15:0] ovf     [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_tx_queue #(.DEPTH(DEPTH), .GAP_CYC(0)) u_dut0 (
    .clk(clk), .rst(rst), .i_WR_En(wr_en), .i_WR_Din(wr_din), .o_WR_Full(full[0]),
    .o_Level(level[0]), .i_TXD_Done(done[0]), .o_TXD_Din(txd_din[0]), .o_TXD_En(txd_en[0]),
    .o_Busy(busy[0]), .o_Ovf_Cnt(ovf[0])
  );

  uart_tx_queue #(.DEPTH(DEPTH), .GAP_CYC(GAP1)) u_dut1 (
    .clk(clk), .rst(rst), .i_WR_En(wr_en), .i_WR_Din(wr_din), .o_WR_Full(full[1]),
    .o_Level(level[1]), .i_TXD_Done(done[1]), .o_TXD_Din(txd_din[1]), .o_TXD_En(txd_en[1]),
    .o_Busy(busy[1]), .o_Ovf_Cnt(ovf[1])
  );

  // Reference model: byte queue plus "a byte is outstanding" flag and the earliest edge at
  // which the scheduler may issue again.
  logic [7:0] mq [2][$];
  bit         out_m  [2];
  bit         en_m   [2];
  bit         full_m [2];
  bit         busy_m [2];
  logic [7:0] din_m  [2];
  int         next_m [2];
  int         ovf_m  [2];
  int         cyc;

  // Stimulus / observation state.
  int         done_cnt  [2];
  bit         answer;
  int         dly_lo, dly_hi, spur_rate;
  int         pulses    [2];
  logic [7:0] cap       [2][$];
  int         last_done [2];
  bit         gap_mode;
  int         gap_base  [2];
  int         gap_hits  [2];

  function automatic int gap_of(input int k);
    return (k == 0) ? 0 : GAP1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      out_m[k]    = 1'b0;
      en_m[k]     = 1'b0;
      full_m[k]   = 1'b0;
      busy_m[k]   = 1'b0;
      din_m[k]    = 8'h00;
      next_m[k]   = 0;
      ovf_m[k]    = 0;
      done_cnt[k] = 0;
      done[k]     = 1'b0;
    end
  endtask

  task automatic model_edge(input int k);
    bit was_send, in_wait, in_idle, acc;
    was_send = en_m[k];
    in_wait  = out_m[k] && !en_m[k];
    in_idle  = !out_m[k] && (cyc >= next_m[k]);
    acc      = wr_en && !full_m[k];
    if (wr_en && full_m[k] && ovf_m[k] < 32'hFFFF) ovf_m[k]++;
    en_m[k] = 1'b0;
    if (was_send) mq[k].delete(0);
    if (in_wait && done[k]) begin
      out_m[k]  = 1'b0;
      next_m[k] = cyc + 1 + gap_of(k);
    end
    if (in_idle && mq[k].size() > 0) begin
      en_m[k]  = 1'b1;
      din_m[k] = mq[k][0];
      out_m[k] = 1'b1;
    end
    if (acc) mq[k].push_back(wr_din);
    full_m[k] = (mq[k].size() == DEPTH);
    busy_m[k] = out_m[k] || (next_m[k] > cyc + 1) || (mq[k].size() != 0);
  endtask

  task automatic compare(input int k);
    check_eq($sformatf("en%0d", k),    32'(txd_en[k]),  32'(en_m[k]));
    check_eq($sformatf("din%0d", k),   32'(txd_din[k]), 32'(din_m[k]));
    check_eq($sformatf("level%0d", k), 32'(level[k]),   32'(mq[k].size()));
    check_eq($sformatf("full%0d", k),  32'(full[k]),    32'(full_m[k]));
    check_eq($sformatf("busy%0d", k),  32'(busy[k]),    32'(busy_m[k]));
`ifdef UART_TXQ_OVF_CNT_EN
    check_eq($sformatf("ovf%0d", k),   32'(ovf[k]),     32'(ovf_m[k]));
`else
    check_eq($sformatf("ovf%0d", k),   32'(ovf[k]),     32'd0);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (done[k]) last_done[k] = cyc;
      model_edge(k);
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      compare(k);
      if (txd_en[k]) begin
        pulses[k]++;
        cap[k].push_back(txd_din[k]);
        if (gap_mode && (pulses[k] - gap_base[k] == 2)) begin
          check_eq($sformatf("gap_spacing%0d", k), 32'(cyc - last_done[k]),
                   32'(1 + gap_of(k)));
          gap_hits[k]++;
        end
      end
      done[k] = 1'b0;
      if (done_cnt[k] > 0) begin
        done_cnt[k]--;
        if (done_cnt[k] == 0) done[k] = 1'b1;
      end
      if (spur_rate != 0 && $urandom_range(spur_rate - 1, 0) == 0) done[k] = 1'b1;
      if (en_m[k] && answer) done_cnt[k] = $urandom_range(dly_hi, dly_lo);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en  = 1'b1;
    wr_din = b;
    step();
    wr_en  = 1'b0;
  endtask

  task automatic drain(input string tag);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 400 && !idle; i++) begin
      step();
      idle = 1'b1;
      for (int k = 0; k < 2; k++) begin
        if (out_m[k] || mq[k].size() != 0 || next_m[k] > cyc + 1 || done_cnt[k] != 0)
          idle = 1'b0;
      end
    end
    check_eq({tag, "_drained"}, 32'(idle), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("%s_en%0d", tag, k),    32'(txd_en[k]),  32'd0);
      check_eq($sformatf("%s_din%0d", tag, k),   32'(txd_din[k]), 32'd0);
      check_eq($sformatf("%s_level%0d", tag, k), 32'(level[k]),   32'd0);
      check_eq($sformatf("%s_full%0d", tag, k),  32'(full[k]),    32'd0);
      check_eq($sformatf("%s_busy%0d", tag, k),  32'(busy[k]),    32'd0);
      check_eq($sformatf("%s_ovf%0d", tag, k),   32'(ovf[k]),     32'd0);
    end
  endtask

  // Asynchronous reset mid-cycle, held for three cycles and released on a falling edge.
  task automatic apply_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_zero({tag, "_async"});
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check_zero({tag, "_held"});
    end
    rst = 1'b0;
  endtask

  initial begin
    string hello;
    int    p0, p1;
    hello     = "HELLO";
    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_din    = 8'h00;
    answer    = 1'b1;
    dly_lo    = 10;
    dly_hi    = 10;
    spur_rate = 0;
    gap_mode  = 1'b0;
    cyc       = 0;
    for (int k = 0; k < 2; k++) begin
      pulses[k] = 0; last_done[k] = 0; gap_base[k] = 0; gap_hits[k] = 0;
    end
    model_reset();
    #2 check_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single byte, done answers 10 cycles after the pulse.
    p0 = pulses[0];
    write_byte(8'h41);
    check_eq("single_lvl_after_wr", 32'(level[0]), 32'd1);
    check_eq("single_no_fallthru",  32'(txd_en[0]), 32'd0);
    step();
    check_eq("single_pulse", 32'(txd_en[0]),  32'd1);
    check_eq("single_din",   32'(txd_din[0]), 32'h41);
    step();
    check_eq("single_lvl_after_pop", 32'(level[0]), 32'd0);
    check_eq("single_pulse_once",    32'(txd_en[0]), 32'd0);
    repeat (30) step();
    check_eq("single_count", 32'(pulses[0] - p0), 32'd1);
    check_eq("single_busy",  32'(busy[0]), 32'd0);

    // "HELLO" burst, short done latency.
    dly_lo = 1; dly_hi = 4;
    cap[0].delete();
    for (int i = 0; i < 5; i++) write_byte(hello[i]);
    drain("hello");
    check_eq("hello_count", 32'(cap[0].size()), 32'd5);
    for (int i = 0; i < 5 && i < cap[0].size(); i++)
      check_eq($sformatf("hello_byte%0d", i), 32'(cap[0][i]), 32'(hello[i]));

    // Gap spacing between consecutive pulses.
    dly_lo = 3; dly_hi = 3;
    gap_mode = 1'b1;
    for (int k = 0; k < 2; k++) begin gap_base[k] = pulses[k]; gap_hits[k] = 0; end
    write_byte(8'h31);
    write_byte(8'h32);
    drain("gap");
    gap_mode = 1'b0;
    check_eq("gap_seen0", 32'(gap_hits[0]), 32'd1);
    check_eq("gap_seen1", 32'(gap_hits[1]), 32'd1);

    // Spurious done while idle and empty.
    p0 = pulses[0]; p1 = pulses[1];
    done[0] = 1'b1; done[1] = 1'b1;
    repeat (6) step();
    check_eq("spur_pulses0", 32'(pulses[0] - p0), 32'd0);
    check_eq("spur_pulses1", 32'(pulses[1] - p1), 32'd0);

    // Overflow: one byte stuck in WAIT, then 20 writes into the empty FIFO.
    answer = 1'b0;
    write_byte(8'hA5);
    repeat (3) step();
    for (int i = 0; i < 20; i++) begin
      write_byte(8'($urandom));
      if (i == 15) check_eq("ovf_full_at16", 32'(full[0]), 32'd1);
    end
    check_eq("ovf_full",  32'(full[1]),  32'd1);
    check_eq("ovf_level", 32'(level[0]), 32'd16);
`ifdef UART_TXQ_OVF_CNT_EN
    check_eq("ovf_count", 32'(ovf[0]), 32'd4);
`else
    check_eq("ovf_count", 32'(ovf[0]), 32'd0);
`endif
    apply_reset("rst_full");

    // Reset in WAIT with three bytes queued.
    for (int i = 0; i < 4; i++) write_byte(8'h60 + 8'(i));
    repeat (2) step();
    check_eq("mid_level", 32'(level[0]), 32'd3);
    apply_reset("rst_mid");
    p0 = pulses[0]; p1 = pulses[1];
    repeat (20) step();
    check_eq("mid_quiet0", 32'(pulses[0] - p0), 32'd0);
    check_eq("mid_quiet1", 32'(pulses[1] - p1), 32'd0);
    answer = 1'b1;
    write_byte(8'h7E);
    drain("mid_restart");
    check_eq("mid_restart0", 32'(pulses[0] - p0), 32'd1);

    // Random traffic: alternating heavy and light write phases with spurious dones.
    dly_lo = 1; dly_hi = 12; spur_rate = 32;
    for (int i = 0; i < 1200; i++) begin
      if (((i / 150) % 2) == 0) wr_en = ($urandom_range(3, 0) != 0);
      else                      wr_en = ($urandom_range(7, 0) == 0);
      wr_din = 8'($urandom);
      step();
    end
    wr_en = 1'b0;
    spur_rate = 0;
    drain("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Byte queue and send scheduler that sits directly upstream of `uart_byte_tx`, replacing hand-built per-character sequencing. A producer writes bytes into an internal FIFO at any rate. The block pops one byte at a time, drives the transmitter's data input and a single-cycle send enable, then waits for the transmitter's done pulse before issuing the next byte.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `AW`, $clog2(DEPTH): address width; derived, never overridden.
- `GAP_CYC`, 0: idle clock cycles inserted after each `i_TXD_Done` before the next byte.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `i_WR_En` in 1: producer write strobe.
- `i_WR_Din` in 8: producer byte.
- `o_WR_Full` out 1: FIFO holds DEPTH bytes.
- `o_Level` out AW+1: current FIFO occupancy, 0..DEPTH.
- `i_TXD_Done` in 1: done pulse from `uart_byte_tx`.
- `o_TXD_Din` out 8: byte to `uart_byte_tx`.
- `o_TXD_En` out 1: one-cycle send pulse to `uart_byte_tx`.
- `o_Busy` out 1: high when the FSM is not in IDLE or `o_Level` ≠ 0.
- `o_Ovf_Cnt` out 16: count of dropped writes (see Configuration).

## Operation
- **Write side**
  - A write with `i_WR_En`=1 and `o_WR_Full`=0 stores the byte.
  - A write while full is dropped. The FIFO is not modified.
  - `o_WR_Full` is registered and derived from the level. A write is rejected whenever full is asserted, even if a pop occurs in the same cycle.
- **FSM states: IDLE, SEND, WAIT, GAP**
  - IDLE → SEND when level > 0.
  - SEND lasts exactly one cycle:
    - `o_TXD_Din` is loaded with the head byte.
    - `o_TXD_En`=1.
    - The head is popped.
  - Then SEND → WAIT.
  - WAIT holds until `i_TXD_Done`=1, then:
    - goes to GAP if `GAP_CYC` > 0;
    - otherwise goes to IDLE.
  - GAP counts down `GAP_CYC` cycles, then → IDLE.
- `i_TXD_Done` is ignored in every state except WAIT.
- `o_TXD_Din` holds the last sent byte until the next SEND.
- There is no fall-through: a byte written into an empty FIFO is not eligible for a pop until the following cycle.
- Simultaneous write and pop updates the level by net 0.
- Read and write pointers are AW bits and wrap modulo DEPTH. The level is AW+1 bits, so full is distinguished from empty.

## Timing
- All outputs reset to 0: `o_TXD_Din`=8'h00, `o_TXD_En`=0, `o_WR_Full`=0, `o_Level`=0, `o_Busy`=0, `o_Ovf_Cnt`=0. The FSM resets to IDLE.
- Write accepted at edge N: `o_Level` increments at N+1.
- Empty FIFO, write at edge N:
  - the FSM sees the non-empty FIFO at N+1;
  - `o_TXD_En` is high during cycle N+1..N+2;
  - `o_Level` decrements at N+2.
- `i_TXD_Done` sampled at edge D, with `GAP_CYC`=0: FSM in IDLE at D+1, next `o_TXD_En` pulse at D+1..D+2 if data is queued.
- With `GAP_CYC`=G: the next pulse is G cycles later.
- `o_TXD_En` is never high for two consecutive cycles.
- Reset asserted mid-transfer:
  - the FIFO contents are discarded;
  - outputs return to their reset values immediately (asynchronous);
  - `uart_byte_tx` shares the same reset.

## Configuration
- Macro `UART_TXQ_OVF_CNT_EN`.
- Defined: `o_Ovf_Cnt` increments on every dropped write and saturates at 16'hFFFF. It is cleared only by reset.
- Undefined: the counter logic is omitted and `o_Ovf_Cnt` is tied to 16'h0000. All other behaviour is identical.

## Structure
- Shared package `uart_pkg`:
  - FSM state typedef (IDLE/SEND/WAIT/GAP);
  - `UART_BYTE_W`=8;
  - baud-select constants shared with `uart_byte_tx`.
- Sub-module `uart_sync_fifo`:
  - parameterised on DEPTH and width;
  - provides registered full, level, and head data.
- The FSM and gap counter stay in `uart_tx_queue`.

## Test plan
- **Single byte.** Setup: reset, one write of 8'h41, done model answers after 10 cycles. Required: exactly one `o_TXD_En` pulse with `o_TXD_Din`=8'h41; `o_Level` goes 0→1→0; `o_Busy` drops one cycle after done.
- **String burst.** Setup: write "HELLO" back-to-back, `GAP_CYC`=0. Required: five pulses in order; each pulse occurs exactly one cycle after the prior done cycle; no pulse while in WAIT.
- **Overflow.** Setup: DEPTH=16, done held low, write 20 bytes. Required: `o_WR_Full`=1 after 16 writes; `o_Level`=16; 4 writes dropped; with macro, `o_Ovf_Cnt`=4, without it `o_Ovf_Cnt`=0.
- **Gap.** Setup: `GAP_CYC`=5, two bytes queued. Required: second pulse exactly 6 cycles after the first done.
- **Spurious done.** Setup: `i_TXD_Done` pulsed while IDLE with an empty FIFO. Required: no state change and no pulse.
- **Reset mid-transfer.** Setup: assert `rst` during WAIT with 3 bytes queued. Required: all outputs read 0 while reset is held; no pulse after release until a new write.
